// File: rtl/rv_pkg.sv
// Shared constants for the register-file writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    // Writeback requester slots on the shared write port.
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_MDU = 2;

    // (base + off) mod n, valid for base < n and off < n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer and wraps.
// Latency: grant is combinational from req; pointer advances on the grant edge.
// Backpressure: ungranted requesters hold req; the grant is forced to zero during rst.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset (pointer -> 0)
//   req       per-requester request
//   gnt       one-hot grant
module rr_arbiter
    import rv_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [NREQ-1:0]  w_gnt;
    logic             w_found;
    int               w_idx;

    always_comb begin
        w_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = wrap_idx(int'(r_ptr), k, NREQ);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                w_gnt[w_idx] = 1'b1;
                // Next search starts just past the winner.
                w_ptr_nxt    = (w_idx == NREQ - 1) ? '0 : PTR_W'(w_idx + 1);
            end
        end
        // No handshake can complete while reset is held.
        if (rst) begin
            w_gnt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign gnt = w_gnt;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the register-file write port among NREQ writeback units and keeps the
// 32-entry busy scoreboard that stalls issue on RAW/WAW hazards.
// Latency: 1 cycle from handshake to registered write-port drive.
// Backpressure: round-robin req_ready, one grant per cycle; issue stalls on busy/shadow.
//
// Ports:
//   iss_*       issue-stage query and accepted-destination reservation
//   iss_stall   combinational hazard stall
//   req_*       packed per-requester writeback requests / one-hot ready
//   wb_en, rd_index, wb_data   registered register-file write port
//   busy_vec    scoreboard state
module rf_wb_scheduler
    import rv_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREQ   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iss_valid,
    input  logic [REG_IDX_W-1:0]      iss_rs1,
    input  logic [REG_IDX_W-1:0]      iss_rs2,
    input  logic [REG_IDX_W-1:0]      iss_rd,
    input  logic                      iss_rd_we,
    output logic                      iss_stall,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [REG_IDX_W*NREQ-1:0] req_rd,
    input  logic [XLEN_P*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wb_en,
    output logic [REG_IDX_W-1:0]      rd_index,
    output logic [XLEN_P-1:0]         wb_data,
    output logic [NUM_REGS-1:0]       busy_vec
);

    logic [NUM_REGS-1:0]  r_busy;
    logic                 r_wb_en;
    logic [REG_IDX_W-1:0] r_rd_index;
    logic [XLEN_P-1:0]    r_wb_data;

    logic [NREQ-1:0]      w_gnt;
    logic                 w_any;
    logic [REG_IDX_W-1:0] w_sel_rd;
    logic [XLEN_P-1:0]    w_sel_data;
    logic                 w_shadow;
    logic                 w_stall;
    logic                 w_set;
    logic                 w_wb_we;
    logic [NUM_REGS-1:0]  w_busy_nxt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (w_gnt)
    );

    // One-hot mux of the granted requester.
    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd   = req_rd[i*REG_IDX_W +: REG_IDX_W];
                w_sel_data = req_data[i*XLEN_P +: XLEN_P];
            end
        end
    end

    assign w_any   = |w_gnt;
    assign w_wb_we = w_any && (w_sel_rd != '0);

    // busy clears on the edge wb_en rises, but the register file only holds
    // the value one edge later; readers of that index wait one extra cycle.
    assign w_shadow = r_wb_en && ((r_rd_index == iss_rs1) || (r_rd_index == iss_rs2));

    assign w_stall = iss_valid && (r_busy[iss_rs1] || r_busy[iss_rs2] ||
                                   (iss_rd_we && r_busy[iss_rd]) || w_shadow);

    assign w_set = iss_valid && !w_stall && iss_rd_we && (iss_rd != '0);

    // Set is applied after clear so it wins on a same-index collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_we) begin
            w_busy_nxt[w_sel_rd] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_wb_en    <= 1'b0;
            r_rd_index <= '0;
            r_wb_data  <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_wb_en <= w_wb_we;
            if (w_any) begin
                r_rd_index <= w_sel_rd;
                r_wb_data  <= w_sel_data;
            end
        end
    end

    assign iss_stall = w_stall;
    assign req_ready = w_gnt;
    assign wb_en     = r_wb_en;
    assign rd_index  = r_rd_index;
    assign wb_data   = r_wb_data;
    assign busy_vec  = r_busy;

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port among NREQ writeback requesters: ALU pipe, load unit and mul/div unit.
- Tracks a 32-entry busy scoreboard so the issue stage stalls on RAW/WAW hazards against in-flight long-latency destinations.
- Sits between the execute units and the register file.
- Drives the register file's wb_en, rd_index and wb_data from registers.

Parameters:
XLEN, 64, data width of writeback values
NREQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = mul/div)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
iss_valid  in  1  issue stage presents an instruction this cycle
iss_rs1  in  5  source register 1 index
iss_rs2  in  5  source register 2 index
iss_rd  in  5  destination register index
iss_rd_we  in  1  instruction writes rd
iss_stall  out  1  issue must hold; hazard on a busy register
req_valid  in  NREQ  per-requester writeback request
req_rd  in  5*NREQ  per-requester destination index, packed, requester i at [5i+4:5i]
req_data  in  XLEN*NREQ  per-requester write data, packed
req_ready  out  NREQ  one-hot grant; handshake completes when valid & ready
wb_en  out  1  register-file write enable (registered)
rd_index  out  5  register-file write index (registered)
wb_data  out  XLEN  register-file write data (registered)
busy_vec  out  32  scoreboard state, for debug/verification

Behaviour:
Reset (asynchronous, rst=1):
- busy_vec=0, round-robin pointer=0.
- wb_en=0, rd_index=0, wb_data=0.
- req_ready=0 while rst is high.

Scoreboard:
- iss_stall is combinational from registered busy_vec:
  iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_rd_we & busy[iss_rd])).
- Index 0 is never busy.
- Accepted issue (iss_valid & ~iss_stall & iss_rd_we & iss_rd!=0) sets busy[iss_rd] at the next edge.
- A completed handshake from requester i clears busy[req_rd_i] at the next edge.
- Set and clear of the same index in one cycle cannot occur, because WAW stalls while busy. If it is forced in simulation anyway, set wins.
- The ALU pipe (req 0) also sets busy via the issue path. Every writer is scoreboarded uniformly.

Arbitration:
- Round-robin, one grant per cycle. req_ready is combinational from req_valid and the pointer.
- The search starts at the pointer index and wraps modulo NREQ. The first valid requester is granted.
- After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Requesters must hold valid, rd and data stable until ready. Dropping valid before the grant is illegal; the bench asserts on it.
- Worst-case wait is NREQ-1 cycles.

Write port:
- On the edge after a grant, the block registers wb_en=1, rd_index=req_rd_i, wb_data=req_data_i. Latency is 1 cycle from handshake to write-port drive.
- The register file commits on the following edge.
- A grant with req_rd=0 completes the handshake, but wb_en is registered 0 and busy is untouched.
- With no grant: wb_en=0, and rd_index/wb_data hold their previous values.

Read-after-clear:
- busy clears on the same edge that wb_en rises, but register-file data is written one edge later.
- Therefore iss_stall additionally asserts if wb_en & rd_index matches rs1/rs2. This is a one-cycle write-shadow stall.

Reset mid-operation:
- All in-flight requests are dropped and busy is cleared.
- Requesters must deassert valid on rst.

Decomposition:
- Shared package rv_pkg: XLEN, REG_IDX_W=5, NUM_REGS=32, requester index constants WB_ALU=0, WB_LSU=1, WB_MDU=2.
- One sub-module, rr_arbiter: parameterised NREQ, holds the pointer, outputs a one-hot grant.
- The scoreboard and write-port registers stay in rf_wb_scheduler.

Test Plan:
1. Reset → busy_vec=0, wb_en=0, req_ready=0. Release rst, no requests → wb_en stays 0.
2. Issue rd=5 → busy_vec[5]=1 next cycle. Issue rs1=5 → iss_stall=1. req1 valid rd=5 data=0xDEAD_BEEF → ready same cycle, then wb_en=1/rd_index=5/wb_data=0xDEADBEEF. busy[5]=0. Stall holds one more shadow cycle, then drops.
3. All three requesters valid continuously with pointer=0 → grants 0,1,2,0 on consecutive cycles, and each wb_data matches the granted requester.
4. req2 valid rd=0 data=0x1234 → ready=1, next-cycle wb_en=0, busy_vec unchanged.
5. Issue rd=7 with busy[7]=1 and iss_rd_we=1 → iss_stall=1 (WAW). With iss_rd_we=0 → iss_stall=0.
6. rst asserted mid-cycle while busy_vec=0x0000_00A0 and req0 pending → busy_vec=0, wb_en=0 immediately (asynchronous), pointer=0 after release.
